// File: rtl/uart_tx_fifo_if.sv
// CPU-side bus of the buffered UART transmitter: write port, overflow control,
// serial line and FIFO status.
interface uart_tx_fifo_if #(
    parameter int AW = 3
);
    logic [7:0]  data_in;
    logic        we;
    logic        clr_ovf;
    logic        data_uart;
    logic        busy;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        overflow;

    modport master (
        output data_in, we, clr_ovf,
        input  data_uart, busy, full, empty, count, overflow
    );

    modport slave (
        input  data_in, we, clr_ovf,
        output data_uart, busy, full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: CPU writes fill a DEPTH-entry FIFO, and a
// frame engine clocked at OVERSAMPLE x baud drains it onto the serial line.
module uart_tx_fifo #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int OVERSAMPLE = 16
) (
    input logic           clock,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);
    localparam int            TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;

    logic [7:0]    r_shift;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit;
    logic          r_txd;

    logic [TW-1:0] w_timer_next;
    logic [2:0]    w_bit_next;
    logic          w_txd_next;
    logic          w_tick;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [AW:0]   w_count_next;

    assign w_tick = (r_timer == TICK_LAST);

    // A pop in the same cycle frees a slot, so a write at full is still taken.
    assign w_wr   = bus.we && (!r_full || w_pop);
    assign w_drop = bus.we && !w_wr;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_FULL);
            r_empty <= (w_count_next == '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_bit == 3'd7)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_state_next = r_empty ? S_IDLE : S_START;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next line level is derived from the next state so data_uart can be a flop.
    always_comb begin
        w_pop        = ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick)) && !r_empty;
        w_timer_next = ((r_state == S_IDLE) || w_tick) ? '0 : r_timer + 1'b1;
        w_bit_next   = '0;
        if (r_state == S_DATA) begin
            w_bit_next = w_tick ? r_bit + 3'd1 : r_bit;
        end
        unique case (w_state_next)
            S_START: w_txd_next = 1'b0;
            S_DATA:  w_txd_next = r_shift[w_bit_next];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
            r_bit   <= '0;
            r_txd   <= 1'b1;
            r_shift <= '0;
        end else begin
            r_timer <= w_timer_next;
            r_bit   <= w_bit_next;
            r_txd   <= w_txd_next;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end
        end
    end

    assign bus.data_uart = r_txd;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.full      = r_full;
    assign bus.empty     = r_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-and-frame-offset reference model.
module tb_uart_tx_fifo;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int OS    = 16;
    localparam int FRAME = 10 * OS;

    logic clock;
    logic reset;

    uart_tx_fifo_if #(.AW(AW)) bus ();

    uart_tx_fifo #(
        .DEPTH(DEPTH),
        .AW(AW),
        .OVERSAMPLE(OS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bytes waiting, the byte on the wire and its frame offset.
    logic [7:0] q[$];
    logic [7:0] cur;
    int         phase = -1;
    logic       m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_line();
        int idx;
        if (phase < 0)      return 1'b1;
        if (phase < OS)     return 1'b0;
        if (phase < 9 * OS) begin
            idx = (phase - OS) / OS;
            return cur[idx];
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        phase = -1;
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [7:0] d, input logic c);
        logic pop;
        logic accept;
        pop    = (q.size() > 0) && ((phase < 0) || (phase == FRAME - 1));
        accept = w && ((q.size() < DEPTH) || pop);
        if (w && !accept)  m_ovf = 1'b1;
        else if (c)        m_ovf = 1'b0;
        if (pop) begin
            cur   = q.pop_front();
            phase = 0;
        end else if (phase == FRAME - 1) begin
            phase = -1;
        end else if (phase >= 0) begin
            phase++;
        end
        if (accept) q.push_back(d);
    endtask

    task automatic compare_all();
        check("data_uart", 32'(bus.data_uart), 32'(exp_line()));
        check("count",     32'(bus.count),     q.size());
        check("full",      32'(bus.full),      32'(q.size() == DEPTH));
        check("empty",     32'(bus.empty),     32'(q.size() == 0));
        check("busy",      32'(bus.busy),      32'(phase >= 0));
        check("overflow",  32'(bus.overflow),  32'(m_ovf));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic c);
        bus.we      = w;
        bus.data_in = d;
        bus.clr_ovf = c;
        @(posedge clock);
        if (reset) model_edge(w, d, c);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // Reset lands mid-cycle; outputs must settle before any clock edge.
    task automatic async_reset();
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_line",  32'(bus.data_uart), 32'd1);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_empty", 32'(bus.empty),     32'd1);
        check("rst_count", 32'(bus.count),     32'd0);
        idle(3);
        reset = 1'b1;
    endtask

    initial begin
        int sent;
        bus.we      = 1'b0;
        bus.data_in = '0;
        bus.clr_ovf = 1'b0;
        reset       = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
        idle(3);
        reset = 1'b1;
        idle(2);

        // Single byte
        step(1'b1, 8'h55, 1'b0);
        check("single_count1", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("single_start", 32'(bus.data_uart), 32'd0);
        check("single_count0", 32'(bus.count), 32'd0);
        idle(FRAME + 10);

        // Back-to-back frames
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        idle(2 * FRAME + 10);

        // Overflow burst while busy
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0);
        check("ovf_full",  32'(bus.full),     32'd1);
        check("ovf_count", 32'(bus.count),    32'd8);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        idle(9 * FRAME + 10);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("ovf_clr", 32'(bus.overflow), 32'd0);

        // Write and pop in the same cycle at full
        step(1'b1, 8'h10, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 2 * FRAME && !(phase == FRAME - 1); i++) idle(1);
        check("wp_sync", 32'(phase == FRAME - 1), 32'd1);
        step(1'b1, 8'h77, 1'b0);
        check("wp_count", 32'(bus.count),    32'd8);
        check("wp_ovf",   32'(bus.overflow), 32'd0);
        idle(9 * FRAME + 10);

        // Reset in the middle of a frame with bytes queued
        step(1'b1, 8'hFF, 1'b0);
        for (int i = 1; i <= 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < FRAME && phase != 40; i++) idle(1);
        check("rst_sync", 32'(phase), 32'd40);
        async_reset();
        idle(2 * FRAME);

        // Pointer wrap: stream 20 bytes, writing only when there is room
        sent = 0;
        for (int i = 0; i < 40 * FRAME && sent < 20; i++) begin
            if (q.size() < DEPTH) begin
                step(1'b1, 8'(sent), 1'b0);
                sent++;
            end else begin
                idle(1);
            end
        end
        check("wrap_sent", 32'(sent), 32'd20);
        idle(9 * FRAME + 10);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 15) == 0), 8'($urandom), ($urandom_range(0, 63) == 0));
        end
        idle(9 * FRAME + 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
